// File: rtl/count_sequencer.sv
// count_sequencer: shares one mod-(TOP+1) preset/step counter between two
// requesters. A round-robin arbiter picks one request in IDLE, the FSM runs
// that preset or multi-step advance to completion, then reports done to the
// owner. All outputs are registered.
module count_sequencer #(
    parameter int WIDTH  = 4,
    parameter int TOP    = 7,
    parameter int PRESET = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       steps0,
    input  logic [2:0]       steps1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] TOP_Q    = WIDTH'(TOP);
    localparam logic [WIDTH-1:0] PRESET_Q = WIDTH'(PRESET);
    localparam logic [WIDTH-1:0] ONE_Q    = WIDTH'(1);

    state_t     state;
    logic [2:0] rem;     // steps still to apply; 0 means preset
    logic       owner;   // requester whose operation is running
    logic       last;    // most recent winner, loses the next tie
    logic       winner;
    logic [2:0] win_steps;
    logic       any_req;

    // Round-robin selection: a lone request wins, a tie goes to the
    // requester that did not win last time.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        winner    = 1'b0;
        win_steps = steps0;
        any_req   = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
        if (winner) begin
            win_steps = steps1;
        end
    end

    // Sequencer FSM with registered grant, done, wrap and busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            rem   <= '0;
            last  <= 1'b1;
            owner <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            // Pulses default low; the cases below raise them for one cycle.
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            wrap  <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_req) begin
                        rem   <= win_steps;
                        owner <= winner;
                        last  <= winner;
                        gnt0  <= ~winner;
                        gnt1  <= winner;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (rem == 3'd0) begin
                        // Preset completes in a single RUN cycle.
                        q     <= PRESET_Q;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= DONE;
                    end else begin
                        if (q == TOP_Q) begin
                            q    <= '0;
                            wrap <= 1'b1;
                        end else begin
                            q <= q + ONE_Q;
                        end
                        rem <= rem - 3'd1;
                        // Last step: the done pulse lines up with the DONE state.
                        if (rem == 3'd1) begin
                            done0 <= ~owner;
                            done1 <= owner;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: a vector table covering single
// requests, wrap, preset, steps changing mid-operation and tie arbitration,
// followed by hand-written sequences for continuous contention and an
// asynchronous reset in the middle of an operation.
module tb_count_sequencer;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [2:0] steps0, steps1;
    logic       gnt0, gnt1, done0, done1;
    logic [3:0] q;
    logic       wrap, busy;

    int checks = 0;
    int errors = 0;

    count_sequencer #(.WIDTH(4), .TOP(7), .PRESET(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .steps0 (steps0),
        .steps1 (steps1),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .done0  (done0),
        .done1  (done1),
        .q      (q),
        .wrap   (wrap),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r0, r1;
        logic [2:0] s0, s1;
        logic       g0, g1, d0, d1;
        logic [3:0] q;
        logic       w, b;
    } vec_t;

    vec_t vecs [34];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {22'd0, gnt0, gnt1, done0, done1, q, wrap, busy};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; steps0 = 3'd0; steps1 = 3'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int grants;
        int next_gnt;
        int cur_owner;
        logic prev_g0, prev_g1;

        // Inputs applied for one cycle; expected outputs in the following cycle.
        //            r0 r1 s0 s1   g0 g1 d0 d1 q  w  b
        vecs[0]  = '{1, 0, 3, 0,   1, 0, 0, 0, 0, 0, 1};
        vecs[1]  = '{0, 0, 3, 0,   0, 0, 0, 0, 1, 0, 1};
        vecs[2]  = '{0, 0, 3, 0,   0, 0, 0, 0, 2, 0, 1};
        vecs[3]  = '{0, 0, 3, 0,   0, 0, 1, 0, 3, 0, 1};
        vecs[4]  = '{0, 0, 3, 0,   0, 0, 0, 0, 3, 0, 0};
        vecs[5]  = '{0, 1, 3, 3,   0, 1, 0, 0, 3, 0, 1};
        vecs[6]  = '{0, 0, 3, 3,   0, 0, 0, 0, 4, 0, 1};
        vecs[7]  = '{0, 0, 3, 3,   0, 0, 0, 0, 5, 0, 1};
        vecs[8]  = '{0, 0, 3, 3,   0, 0, 0, 1, 6, 0, 1};
        vecs[9]  = '{0, 0, 3, 3,   0, 0, 0, 0, 6, 0, 0};
        vecs[10] = '{0, 1, 3, 3,   0, 1, 0, 0, 6, 0, 1};
        vecs[11] = '{0, 0, 3, 3,   0, 0, 0, 0, 7, 0, 1};
        vecs[12] = '{0, 0, 3, 3,   0, 0, 0, 0, 0, 1, 1};
        vecs[13] = '{0, 0, 3, 3,   0, 0, 0, 1, 1, 0, 1};
        vecs[14] = '{0, 0, 3, 3,   0, 0, 0, 0, 1, 0, 0};
        vecs[15] = '{1, 0, 1, 3,   1, 0, 0, 0, 1, 0, 1};
        vecs[16] = '{0, 0, 1, 3,   0, 0, 1, 0, 2, 0, 1};
        vecs[17] = '{0, 0, 1, 3,   0, 0, 0, 0, 2, 0, 0};
        vecs[18] = '{1, 0, 0, 3,   1, 0, 0, 0, 2, 0, 1};
        vecs[19] = '{0, 0, 0, 3,   0, 0, 1, 0, 4, 0, 1};
        vecs[20] = '{0, 0, 0, 3,   0, 0, 0, 0, 4, 0, 0};
        vecs[21] = '{1, 0, 5, 3,   1, 0, 0, 0, 4, 0, 1};
        vecs[22] = '{0, 0, 1, 3,   0, 0, 0, 0, 5, 0, 1};
        vecs[23] = '{0, 0, 1, 3,   0, 0, 0, 0, 6, 0, 1};
        vecs[24] = '{0, 0, 1, 3,   0, 0, 0, 0, 7, 0, 1};
        vecs[25] = '{0, 0, 1, 3,   0, 0, 0, 0, 0, 1, 1};
        vecs[26] = '{0, 0, 1, 3,   0, 0, 1, 0, 1, 0, 1};
        vecs[27] = '{0, 0, 1, 3,   0, 0, 0, 0, 1, 0, 0};
        vecs[28] = '{1, 1, 1, 1,   0, 1, 0, 0, 1, 0, 1};
        vecs[29] = '{1, 0, 1, 1,   0, 0, 0, 1, 2, 0, 1};
        vecs[30] = '{1, 0, 1, 1,   0, 0, 0, 0, 2, 0, 0};
        vecs[31] = '{1, 0, 1, 1,   1, 0, 0, 0, 2, 0, 1};
        vecs[32] = '{0, 0, 1, 1,   0, 0, 1, 0, 3, 0, 1};
        vecs[33] = '{0, 0, 1, 1,   0, 0, 0, 0, 3, 0, 0};

        // ---- reset state ----
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; steps0 = 3'd0; steps1 = 3'd0;
        #2;
        check("reset_outputs", outs(), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // ---- vector table ----
        for (int i = 0; i < 34; i++) begin
            req0   = vecs[i].r0;
            req1   = vecs[i].r1;
            steps0 = vecs[i].s0;
            steps1 = vecs[i].s1;
            tick();
            check($sformatf("vec%0d {g0,g1,d0,d1,q,wrap,busy}", i), outs(),
                  {22'd0, vecs[i].g0, vecs[i].g1, vecs[i].d0, vecs[i].d1,
                   vecs[i].q, vecs[i].w, vecs[i].b});
        end

        // ---- both requests held: strict alternation starting with 0 ----
        do_reset();
        req0 = 1'b1; req1 = 1'b1; steps0 = 3'd1; steps1 = 3'd2;
        grants    = 0;
        next_gnt  = 0;
        cur_owner = -1;
        prev_g0   = 1'b0;
        prev_g1   = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            tick();
            check($sformatf("rr_gnt_overlap c%0d", c), {31'd0, gnt0 & gnt1}, 32'd0);
            check($sformatf("rr_done_overlap c%0d", c), {31'd0, done0 & done1}, 32'd0);
            if (gnt0 || gnt1) begin
                check($sformatf("rr_gnt_width c%0d", c), {31'd0, (gnt0 & prev_g0) | (gnt1 & prev_g1)}, 32'd0);
                check($sformatf("rr_gnt_order c%0d", c), {31'd0, gnt1}, next_gnt);
                cur_owner = gnt1 ? 1 : 0;
                next_gnt  = 1 - next_gnt;
                grants++;
            end
            if (done0 || done1) begin
                check($sformatf("rr_done_owner c%0d", c), {31'd0, done1}, cur_owner);
            end
            prev_g0 = gnt0;
            prev_g1 = gnt1;
        end
        check("rr_grant_count", grants, 32'd10);
        check("rr_final_q", {28'd0, q}, 32'd7);

        // ---- async reset mid-RUN of a 7-step op at q=3 ----
        do_reset();
        req0 = 1'b1; req1 = 1'b0; steps0 = 3'd7;
        tick();
        check("rst_run_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        tick();
        tick();
        tick();
        check("rst_run_q_before", {28'd0, q}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("rst_run_immediate", outs(), 32'd0);
        tick();
        check("rst_run_held", outs(), 32'd0);
        #3;
        reset = 1'b0;
        // No done may surface after release while idle.
        tick();
        check("rst_run_no_done", outs(), 32'd0);
        req0 = 1'b1; req1 = 1'b1; steps0 = 3'd2; steps1 = 3'd2;
        tick();
        check("rst_after_gnt", outs(), {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1});
        req0 = 1'b0;
        tick();
        tick();
        check("rst_after_done", outs(), {22'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
